// File: rtl/max3_win_ctrl.sv
// -----------------------------------------------------------------------------
// max3_win_ctrl
//
// Purpose:
//   Streaming 1-D horizontal max filter. Each output pixel of a line is the
//   maximum of its left neighbour, itself and its right neighbour. The line
//   edges are replicated, so p[-1] = p[0] and p[LINE_WIDTH] = p[LINE_WIDTH-1].
//   The output is the same width as the input. Nothing carries over from one
//   line to the next.
//
// Parameters:
//   DATA_WIDTH  pixel width in bits (default 8)
//   LINE_WIDTH  pixels per line, legal range 2..4095 (default 640)
//
// Ports:
//   clk      sole clock, rising edge
//   rst      asynchronous, active-high reset
//   s_valid  input pixel valid
//   s_ready  input pixel accepted when s_valid && s_ready
//   s_data   input pixel, raster order
//   m_valid  output pixel valid
//   m_ready  downstream accepts when m_valid && m_ready
//   m_data   filtered pixel
//   m_last   (only with MAX3_WIN_LAST_EN) marks the last pixel of a line
//   busy     high whenever a line is in progress or an output is pending
//
// Optional feature:
//   Define MAX3_WIN_LAST_EN to add the m_last output. Without it the port does
//   not exist and everything else behaves the same.
// -----------------------------------------------------------------------------

// Three-input unsigned maximum, purely combinational.
module Max3 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [DATA_WIDTH-1:0] i_c,
  output logic [DATA_WIDTH-1:0] o_max
);

  logic [DATA_WIDTH-1:0] w_ab;

  assign w_ab  = (i_a >= i_b) ? i_a : i_b;
  assign o_max = (w_ab >= i_c) ? w_ab : i_c;

endmodule

module max3_win_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef MAX3_WIN_LAST_EN
  output logic                  m_last,
`endif
  output logic                  busy
);

  localparam int COL_W = $clog2(LINE_WIDTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);

  // IDLE: no pixel of the current line held; FILL: p[0] held;
  // RUN: mid-line; FLUSH: last pixel taken, final output still to load.
  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [COL_W-1:0]      r_col;
  logic [COL_W-1:0]      w_nextCol;

  // r_winOld holds p[i-2] and r_winMid holds p[i-1]. The newest tap of the
  // window is the pixel being accepted this cycle, which is what allows y[i-1]
  // to be loaded in the same cycle that p[i] arrives.
  logic [DATA_WIDTH-1:0] r_winOld;
  logic [DATA_WIDTH-1:0] r_winMid;
  logic [DATA_WIDTH-1:0] w_winNew;
  logic                  w_winPrime;
  logic                  w_winShift;

  logic [DATA_WIDTH-1:0] w_max;
  logic                  w_load;
  logic                  w_accept;
  logic                  w_outFree;
  logic                  w_isLastCol;

  logic                  r_mValid;
  logic [DATA_WIDTH-1:0] r_mData;

  // The output register can take a new value when it is empty or is being
  // drained this cycle, which gives one pixel per cycle sustained.
  assign w_outFree   = !r_mValid || m_ready;
  assign s_ready     = w_outFree && (r_state != FLUSH) && !rst;
  assign w_accept    = s_valid && s_ready;
  assign w_isLastCol = (r_col == LAST_COL);

  assign m_valid = r_mValid;
  assign m_data  = r_mData;
  assign busy    = (r_state != IDLE) || r_mValid;

  Max3 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_max3 (
    .i_a  (r_winOld),
    .i_b  (r_winMid),
    .i_c  (w_winNew),
    .o_max(w_max)
  );

  // State and column register. Reset abandons any partial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_col   <= '0;
    end else begin
      r_state <= w_nextState;
      r_col   <= w_nextCol;
    end
  end

  // Next-state logic. Pixel 0 primes both stored taps so the left edge is
  // replicated. In FLUSH no pixel is coming, so the newest tap repeats
  // p[LINE_WIDTH-1] to replicate the right edge. With LINE_WIDTH=2 the
  // second pixel is also the last, so FILL may go straight to FLUSH.
  always_comb begin
    w_nextState = r_state;
    w_nextCol   = r_col;
    w_winPrime  = 1'b0;
    w_winShift  = 1'b0;
    w_load      = 1'b0;
    w_winNew    = s_data;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = FILL;
          w_nextCol   = r_col + COL_W'(1);
          w_winPrime  = 1'b1;
        end
      end
      FILL, RUN: begin
        if (w_accept) begin
          w_load     = 1'b1;
          w_winShift = 1'b1;
          if (w_isLastCol) begin
            w_nextState = FLUSH;
            w_nextCol   = '0;
          end else begin
            w_nextState = RUN;
            w_nextCol   = r_col + COL_W'(1);
          end
        end
      end
      FLUSH: begin
        w_winNew = r_winMid;
        if (w_outFree) begin
          w_load      = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCol   = '0;
      end
    endcase
  end

  // Window taps: primed with p[0] at line start, shifted on every later
  // accepted pixel of the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_winOld <= '0;
      r_winMid <= '0;
    end else if (w_winPrime) begin
      r_winOld <= s_data;
      r_winMid <= s_data;
    end else if (w_winShift) begin
      r_winOld <= r_winMid;
      r_winMid <= s_data;
    end
  end

  // One-entry output register. Data holds under backpressure; valid drops
  // only after a transfer that is not paired with a new load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mValid <= 1'b0;
      r_mData  <= '0;
    end else if (w_load) begin
      r_mValid <= 1'b1;
      r_mData  <= w_max;
    end else if (m_ready) begin
      r_mValid <= 1'b0;
    end
  end

`ifdef MAX3_WIN_LAST_EN
  logic r_mLast;
  logic w_loadLast;

  // The only load made from FLUSH is y[LINE_WIDTH-1].
  assign w_loadLast = (r_state == FLUSH);
  assign m_last     = r_mLast;

  // The last flag travels with the output register and clears when that
  // entry drains with nothing new behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mLast <= 1'b0;
    end else if (w_load) begin
      r_mLast <= w_loadLast;
    end else if (m_ready) begin
      r_mLast <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_max3_win_ctrl.sv
// -----------------------------------------------------------------------------
// tb_max3_win_ctrl
//
// Directed table of lines on a LINE_WIDTH=4 instance, hand-written sequences
// for backpressure and mid-line reset, and two free-running random instances
// (LINE_WIDTH=2 and 640) checked against a reference max filter. Defining
// MAX3_WIN_LAST_EN also checks m_last.
// -----------------------------------------------------------------------------
module tb_max3_win_ctrl;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int NVEC = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit randDone [2];

  logic          rst    = 1'b1;
  logic          sValid = 1'b0;
  logic          sReady;
  logic [DW-1:0] sData  = '0;
  logic          mValid;
  logic          mReady = 1'b0;
  logic [DW-1:0] mData;
  logic          busy;
`ifdef MAX3_WIN_LAST_EN
  logic          mLast;
`endif

  max3_win_ctrl #(
    .DATA_WIDTH(DW),
    .LINE_WIDTH(LW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(sValid),
    .s_ready(sReady),
    .s_data (sData),
    .m_valid(mValid),
    .m_ready(mReady),
    .m_data (mData),
`ifdef MAX3_WIN_LAST_EN
    .m_last (mLast),
`endif
    .busy   (busy)
  );

  logic [DW-1:0] gotData [$];
  bit            gotLast [$];

  // Collect every completed output transfer of the directed instance.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (mValid && mReady) begin
        gotData.push_back(mData);
`ifdef MAX3_WIN_LAST_EN
        gotLast.push_back(mLast);
`else
        gotLast.push_back(1'b0);
`endif
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one pixel and hold it until the DUT takes it.
  task automatic applyStimulus(input logic [DW-1:0] pix);
    bit accepted;
    accepted = 1'b0;
    @(negedge clk);
    sValid = 1'b1;
    sData  = pix;
    for (int k = 0; k < 64 && !accepted; k++) begin
      #4;
      if (sReady) accepted = 1'b1;
      else @(negedge clk);
    end
    if (!accepted) checkOutput("accept timeout", 0, 1);
    @(posedge clk);
    #1;
    sValid = 1'b0;
    sData  = 8'hA5;
  endtask

  // Wait for n outputs, then a few more cycles to catch any extra ones.
  task automatic waitOutputs(input int n);
    for (int k = 0; k < 300 && gotData.size() < n; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("output count", gotData.size(), n);
  endtask

  task automatic checkLine(input string tag, input int base,
                           input logic [DW-1:0] exp [LW]);
    for (int i = 0; i < LW; i++) begin
      logic [DW-1:0] act;
      bit            actLast;
      act     = (base + i < gotData.size()) ? gotData[base + i] : 'x;
      actLast = (base + i < gotLast.size()) ? gotLast[base + i] : 1'b0;
      checkOutput($sformatf("%s y%0d", tag, i), act, exp[i]);
`ifdef MAX3_WIN_LAST_EN
      checkOutput($sformatf("%s last%0d", tag, i), actLast, (i == LW - 1));
`else
      if (actLast) checkOutput("last flag without feature", 1, 0);
`endif
    end
  endtask

  typedef struct {
    logic [DW-1:0] px [LW];
    logic [DW-1:0] y  [LW];
  } vec_t;

  vec_t          vecs [NVEC];
  logic [DW-1:0] refLine [LW];
  bit            seen;

  initial begin
    vecs[0].px = '{8'd3,   8'd9,   8'd1,   8'd5};
    vecs[0].y  = '{8'd9,   8'd9,   8'd9,   8'd5};
    vecs[1].px = '{8'd7,   8'd2,   8'd2,   8'd8};
    vecs[1].y  = '{8'd7,   8'd7,   8'd8,   8'd8};
    vecs[2].px = '{8'd255, 8'd0,   8'd0,   8'd0};
    vecs[2].y  = '{8'd255, 8'd255, 8'd0,   8'd0};
    vecs[3].px = '{8'd1,   8'd2,   8'd3,   8'd4};
    vecs[3].y  = '{8'd2,   8'd3,   8'd4,   8'd4};
    vecs[4].px = '{8'd4,   8'd3,   8'd2,   8'd1};
    vecs[4].y  = '{8'd4,   8'd4,   8'd3,   8'd2};
    vecs[5].px = '{8'd0,   8'd200, 8'd0,   8'd100};
    vecs[5].y  = '{8'd200, 8'd200, 8'd200, 8'd100};
    refLine    = '{8'd9,   8'd9,   8'd9,   8'd5};

    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset m_valid", mValid, 0);
    checkOutput("reset m_data", mData, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset s_ready", sReady, 0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    checkOutput("post-reset s_ready", sReady, 1);

    // All table lines back to back with the sink always ready.
    $display("[TB] directed table");
    mReady = 1'b1;
    gotData.delete();
    gotLast.delete();
    for (int v = 0; v < NVEC; v++)
      for (int i = 0; i < LW; i++) applyStimulus(vecs[v].px[i]);
    waitOutputs(NVEC * LW);
    for (int v = 0; v < NVEC; v++) checkLine($sformatf("vec%0d", v), v * LW, vecs[v].y);
    #1;
    checkOutput("idle busy", busy, 0);
    checkOutput("idle m_valid", mValid, 0);

    // Backpressure: hold the first output for 5 cycles.
    $display("[TB] backpressure");
    gotData.delete();
    gotLast.delete();
    @(negedge clk);
    mReady = 1'b0;
    seen   = 1'b0;
    fork
      begin
        for (int i = 0; i < LW; i++) applyStimulus(vecs[0].px[i]);
      end
      begin
        for (int k = 0; k < 50 && !seen; k++) begin
          @(negedge clk);
          #4;
          if (mValid) seen = 1'b1;
        end
        checkOutput("stall first valid", seen, 1);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          #4;
          checkOutput("stall m_valid", mValid, 1);
          checkOutput("stall m_data", mData, 9);
          checkOutput("stall s_ready", sReady, 0);
        end
        @(negedge clk);
        mReady = 1'b1;
      end
    join
    waitOutputs(LW);
    checkLine("stall", 0, refLine);

    // Reset after two pixels of a line, then a clean line.
    $display("[TB] mid-line reset");
    gotData.delete();
    gotLast.delete();
    applyStimulus(8'd3);
    applyStimulus(8'd9);
    checkOutput("pre-reset m_valid", mValid, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst m_valid", mValid, 0);
    checkOutput("rst m_data", mData, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst s_ready", sReady, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gotData.delete();
    gotLast.delete();
    for (int i = 0; i < LW; i++) applyStimulus(vecs[0].px[i]);
    waitOutputs(LW);
    checkLine("after reset", 0, refLine);

    // Random instances run on their own; wait for both to finish.
    for (int k = 0; k < 60000 && !(randDone[0] && randDone[1]); k++) @(negedge clk);
    checkOutput("random runs finished", randDone[0] && randDone[1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Random s_valid / m_ready traffic against a reference max filter.
  for (genvar g = 0; g < 2; g++) begin : gRand
    localparam int RLW    = (g == 0) ? 2 : 640;
    localparam int NLINES = (g == 0) ? 400 : 12;

    logic          rstR   = 1'b1;
    logic          vldIn  = 1'b0;
    logic          rdyIn;
    logic [DW-1:0] dIn    = '0;
    logic          vldOut;
    logic          rdyOut = 1'b0;
    logic [DW-1:0] dOut;
    logic          busyOut;
    logic          lastOut;
    logic [DW-1:0] expQ [$];
    bit            expLastQ [$];

`ifndef MAX3_WIN_LAST_EN
    assign lastOut = 1'b0;
`endif

    max3_win_ctrl #(
      .DATA_WIDTH(DW),
      .LINE_WIDTH(RLW)
    ) dutR (
      .clk    (clk),
      .rst    (rstR),
      .s_valid(vldIn),
      .s_ready(rdyIn),
      .s_data (dIn),
      .m_valid(vldOut),
      .m_ready(rdyOut),
      .m_data (dOut),
`ifdef MAX3_WIN_LAST_EN
      .m_last (lastOut),
`endif
      .busy   (busyOut)
    );

    function automatic logic [DW-1:0] refY(input logic [DW-1:0] ln [RLW], input int i);
      int            lo;
      int            hi;
      logic [DW-1:0] m;
      lo = (i == 0) ? 0 : i - 1;
      hi = (i == RLW - 1) ? RLW - 1 : i + 1;
      m  = ln[lo];
      if (ln[i] > m) m = ln[i];
      if (ln[hi] > m) m = ln[hi];
      return m;
    endfunction

    initial begin : src
      logic [DW-1:0] ln [RLW];
      bit            done;
      repeat (3) @(negedge clk);
      rstR = 1'b0;
      for (int l = 0; l < NLINES; l++) begin
        for (int i = 0; i < RLW; i++) ln[i] = DW'($urandom);
        for (int i = 0; i < RLW; i++) begin
          expQ.push_back(refY(ln, i));
          expLastQ.push_back(i == RLW - 1);
        end
        for (int i = 0; i < RLW; i++) begin
          done = 1'b0;
          for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            vldIn = ($urandom_range(0, 3) != 0);
            dIn   = vldIn ? ln[i] : DW'($urandom);
            #4;
            if (vldIn && rdyIn) done = 1'b1;
          end
          if (!done) checkOutput($sformatf("rand%0d accept timeout", RLW), 0, 1);
        end
      end
      @(negedge clk);
      vldIn = 1'b0;
    end

    initial begin : snk
      int            recvd;
      logic [DW-1:0] e;
      bit            eLast;
      recvd = 0;
      for (int k = 0; k < 40000 && recvd < RLW * NLINES; k++) begin
        @(negedge clk);
        rdyOut = ($urandom_range(0, 3) != 0);
        #4;
        if (vldOut && rdyOut) begin
          if (expQ.size() == 0) begin
            checkOutput($sformatf("rand%0d unexpected output", RLW), 1, 0);
          end else begin
            e     = expQ.pop_front();
            eLast = expLastQ.pop_front();
            checkOutput($sformatf("rand%0d data", RLW), dOut, e);
`ifdef MAX3_WIN_LAST_EN
            checkOutput($sformatf("rand%0d last", RLW), lastOut, eLast);
`else
            if (lastOut || (eLast && 1'b0)) checkOutput("rand last", 1, 0);
`endif
          end
          recvd++;
        end
      end
      checkOutput($sformatf("rand%0d output count", RLW), recvd, RLW * NLINES);
      randDone[g] = 1'b1;
    end
  end

endmodule
